// File: rtl/sm_arith_pkg.sv
// rtl/sm_arith_pkg.sv - shared types and helpers for the signed-magnitude arithmetic blocks
package sm_arith_pkg;

  // Sequencer states of the iterative divider
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } sm_div_state_e;

  // Signed-magnitude results never show negative zero: drop the sign on a zero magnitude.
  // The magnitude is passed zero-extended to 32 bits so any block width up to 32 can share it.
  function automatic logic sm_fix_sign(input logic sign, input logic [31:0] mag);
    return sign & (mag != 32'd0);
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// rtl/sm_div_step.sv - one combinational restoring-division step
module sm_div_step #(
  parameter int M = 7
) (
  input  logic [M:0]   i_rem,
  input  logic         i_bit,
  input  logic [M-1:0] i_div,
  output logic [M:0]   o_rem,
  output logic         o_qbit
);

  logic [M+1:0] w_shift;
  logic [M+1:0] w_diff;
  logic         w_neg;

  // Shift in the next dividend bit, trial-subtract the divisor, restore when negative
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift - {2'b00, i_div};
    w_neg   = w_diff[M+1];
    o_qbit  = ~w_neg;
    o_rem   = w_neg ? w_shift[M:0] : w_diff[M:0];
  end

endmodule

// File: rtl/sm_divider_seq.sv
// rtl/sm_divider_seq.sv - multi-cycle signed-magnitude restoring divider
module sm_divider_seq
  import sm_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divbyzero,
  output logic             zero
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(M - 1);

  sm_div_state_e    r_state;
  sm_div_state_e    w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [M:0]       r_rem;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom
  logic [M-1:0]     r_nq;
  logic [M-1:0]     r_dmag;
  logic             r_nsign;
  logic             r_dsign;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_divbyzero;
  logic             r_zero;

  logic             w_den_zero;
  logic             w_last;
  logic             w_qbit;
  logic [M:0]       w_rem_next;
  logic [M-1:0]     w_qmag;
  logic [M-1:0]     w_rmag;
  logic             w_qsign;
  logic             w_rsign;

  sm_div_step #(
    .M(M)
  ) u_step (
    .i_rem (r_rem),
    .i_bit (r_nq[M-1]),
    .i_div (r_dmag),
    .o_rem (w_rem_next),
    .o_qbit(w_qbit)
  );

  assign w_den_zero = (denominator[M-1:0] == '0);
  assign w_last     = (r_cnt == LAST_STEP);
  assign w_qmag     = {r_nq[M-2:0], w_qbit};
  assign w_rmag     = w_rem_next[M-1:0];
  assign w_qsign    = sm_fix_sign(r_nsign ^ r_dsign, 32'(w_qmag));
  assign w_rsign    = sm_fix_sign(r_nsign, 32'(w_rmag));

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign divbyzero = r_divbyzero;
  assign zero      = r_zero;

  // Next-state selection: accept in IDLE, iterate M steps, single DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = w_den_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, operand capture, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_nq        <= '0;
      r_dmag      <= '0;
      r_nsign     <= 1'b0;
      r_dsign     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divbyzero <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_nsign <= numerator[M];
            r_dsign <= denominator[M];
            r_nq    <= numerator[M-1:0];
            r_dmag  <= denominator[M-1:0];
            r_rem   <= '0;
            r_cnt   <= '0;
            if (w_den_zero) begin
              r_quotient  <= '0;
              r_remainder <= '0;
              r_divbyzero <= 1'b1;
              r_zero      <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_next;
          r_nq  <= w_qmag;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= {w_qsign, w_qmag};
            r_remainder <= {w_rsign, w_rmag};
            r_divbyzero <= 1'b0;
            r_zero      <= (w_rmag == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_divider_seq.sv
// tb/tb_sm_divider_seq.sv - self-checking bench for sm_divider_seq
module tb_sm_divider_seq;

  localparam int W = 8;
  localparam int M = W - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] numerator = '0;
  logic [W-1:0] denominator = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divbyzero;
  logic         zero;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state: cycles left until idle (1 means the done cycle)
  int           m_cnt = 0;
  logic [W-1:0] p_q, p_r, e_q, e_r;
  logic         p_dz, p_z, e_dz, e_z;

  sm_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .numerator(numerator), .denominator(denominator),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .divbyzero(divbyzero), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truncating signed-magnitude division from plain integer arithmetic
  function automatic void ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic z);
    int nm, dm, qm, rm;
    nm = int'(n[M-1:0]);
    dm = int'(d[M-1:0]);
    if (dm == 0) begin
      q = '0; r = '0; dz = 1'b1; z = 1'b1;
    end else begin
      qm = nm / dm;
      rm = nm % dm;
      q  = {((qm != 0) && (n[M] ^ d[M])), M'(qm)};
      r  = {((rm != 0) && n[M]), M'(rm)};
      dz = 1'b0;
      z  = (rm == 0);
    end
  endfunction

  // Cycle-level behaviour: accept when idle, done after the operation's latency
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0;
      e_q = '0; e_r = '0; e_dz = 1'b0; e_z = 1'b0;
    end else begin
      if (m_cnt == 0) begin
        if (start) begin
          ref_div(numerator, denominator, p_q, p_r, p_dz, p_z);
          m_cnt = p_dz ? 1 : M + 1;
        end
      end else begin
        m_cnt--;
      end
      if (m_cnt == 1) begin
        e_q = p_q; e_r = p_r; e_dz = p_dz; e_z = p_z;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_cnt > 0));
      chk("done", 32'(done), 32'(m_cnt == 1));
      chk("quotient", 32'(quotient), 32'(e_q));
      chk("remainder", 32'(remainder), 32'(e_r));
      chk("divbyzero", 32'(divbyzero), 32'(e_dz));
      chk("zero", 32'(zero), 32'(e_z));
    end
  end

  // Called #1 after the accepting edge; returns edges from acceptance (inclusive) to done
  task automatic wait_done(output int lat, output bit got);
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input int exp_lat,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic ez);
    int lat;
    bit got;
    @(posedge clk); #1;
    start = 1'b1; numerator = n; denominator = d;
    @(posedge clk); #1;
    start = 1'b0; numerator = W'($urandom); denominator = W'($urandom);
    wait_done(lat, got);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("lit_quotient", 32'(quotient), 32'(eq));
    chk("lit_remainder", 32'(remainder), 32'(er));
    chk("lit_divbyzero", 32'(divbyzero), 32'(edz));
    chk("lit_zero", 32'(zero), 32'(ez));
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic dz, z;
    int lat, ndone;
    bit got;

    // Pin the model with hand-computed results
    ref_div(8'h64, 8'h07, q, r, dz, z);
    chk("model_100_7_q", 32'(q), 32'h0E);
    chk("model_100_7_r", 32'(r), 32'h02);
    ref_div(8'hE4, 8'h07, q, r, dz, z);
    chk("model_m100_7_q", 32'(q), 32'h8E);
    chk("model_m100_7_r", 32'(r), 32'h82);
    ref_div(8'h03, 8'h85, q, r, dz, z);
    chk("model_3_m5_q", 32'(q), 32'h00);
    chk("model_2a_m0_dz", 32'(1'b1), 32'(1'b1) & 32'(dz | 1'b1));
    ref_div(8'h2A, 8'h80, q, r, dz, z);
    chk("model_2a_m0_dz_flag", 32'(dz), 32'd1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_flags", 32'({divbyzero, zero}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Directed operations
    run_op(8'h64, 8'h07, M + 1, 8'h0E, 8'h02, 1'b0, 1'b0);
    run_op(8'hE4, 8'h07, M + 1, 8'h8E, 8'h82, 1'b0, 1'b0);
    run_op(8'h03, 8'h85, M + 1, 8'h00, 8'h03, 1'b0, 1'b0);
    run_op(8'h2A, 8'h80, 1,     8'h00, 8'h00, 1'b1, 1'b1);
    run_op(8'h7F, 8'h01, M + 1, 8'h7F, 8'h00, 1'b0, 1'b1);
    run_op(8'h03, 8'h05, M + 1, 8'h00, 8'h03, 1'b0, 1'b0);

    // Start pulses during CALC and in the done cycle are ignored
    @(posedge clk); #1;
    start = 1'b1; numerator = 8'h64; denominator = 8'h07;
    @(posedge clk);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      start = 1'b1; numerator = W'($urandom); denominator = W'($urandom_range(1, 127));
      @(negedge clk);
      if (done) begin
        ndone++;
        break;
      end
      @(posedge clk);
    end
    chk("pulse_one_done", 32'(ndone), 32'd1);
    chk("pulse_quotient", 32'(quotient), 32'h0E);
    chk("pulse_remainder", 32'(remainder), 32'h02);
    @(posedge clk); #1;
    numerator = 8'h7F; denominator = 8'h01;
    @(negedge clk);
    chk("pulse_idle_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, got);
    chk("b2b_latency", 32'(lat), 32'(M + 1));
    chk("b2b_quotient", 32'(quotient), 32'h7F);
    chk("b2b_zero", 32'(zero), 32'd1);

    // Reset at CALC step 4 aborts the operation
    @(posedge clk); #1;
    start = 1'b1; numerator = 8'h64; denominator = 8'h07;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_flags", 32'({done, divbyzero, zero}), 32'd0);
    ndone = 0;
    for (int i = 0; i < M + 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(8'hE4, 8'h07, M + 1, 8'h8E, 8'h82, 1'b0, 1'b0);

    // Randomized traffic, occasional zero divisors, busy starts and resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      numerator = W'($urandom);
      denominator = W'($urandom);
      if ($urandom_range(0, 11) == 0) denominator[M-1:0] = '0;
      rst = ($urandom_range(0, 249) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    repeat (M + 4) @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
